// File: rtl/tmds_pkg.sv
// Shared constants for the TMDS encoder: control/guard symbols, preamble code,
// disparity width and the pixel bundle carried through the optional delay line.
package tmds_pkg;

  localparam int CNT_W = 5;

  localparam logic [9:0] CTRL_SYM_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_SYM_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_SYM_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_SYM_11 = 10'b1010101011;

  localparam logic [9:0] GUARD_BLUE  = 10'b1011001100;
  localparam logic [9:0] GUARD_GREEN = 10'b0100110011;
  localparam logic [9:0] GUARD_RED   = 10'b1011001100;

  // {CTL3, CTL2, CTL1, CTL0} announcing a video data period
  localparam logic [3:0] PREAMBLE_VIDEO = 4'b0001;

  localparam int GUARD_DELAY = 10;
  localparam int GUARD_LEN   = 2;

  typedef struct packed {
    logic       blank;
    logic       hsync;
    logic       vsync;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } pixel_t;

  localparam pixel_t PIXEL_IDLE = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};

  function automatic logic [9:0] ctrl_symbol(input logic [1:0] ctl);
    case (ctl)
      2'b00:   ctrl_symbol = CTRL_SYM_00;
      2'b01:   ctrl_symbol = CTRL_SYM_01;
      2'b10:   ctrl_symbol = CTRL_SYM_10;
      default: ctrl_symbol = CTRL_SYM_11;
    endcase
  endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// One TMDS channel: stage 1 does transition minimisation, stage 2 does DC
// balancing with its own running disparity and control/guard symbol insertion.
module tmds_channel_encoder
  import tmds_pkg::*;
(
  input  logic       clk_pixel,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic [1:0] ctl,
  input  logic       blank,
  input  logic       guard,
  input  logic [9:0] guard_sym,
  output logic [9:0] sym
);

  logic [8:0]       q_m_d, q_m_q;
  logic             blank_d, blank_q;
  logic             guard_d, guard_q;
  logic [1:0]       ctl_d, ctl_q;
  logic [9:0]       sym_d, sym_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  logic [3:0]       n1d;
  logic             use_xnor;
  logic [3:0]       n1;
  logic [CNT_W-1:0] disp;
  logic             cnt_zero, cnt_pos, cnt_neg;

  always_comb begin
    n1d      = 4'($countones(data));
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data[0]);
    q_m_d    = '0;
    q_m_d[0] = data[0];
    for (int i = 1; i < 8; i++) begin
      q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ data[i]) : (q_m_d[i-1] ^ data[i]);
    end
    q_m_d[8] = ~use_xnor;
    blank_d  = blank;
    guard_d  = guard;
    ctl_d    = ctl;
  end

  // disp is n1 - n0 of the stage-1 word, kept in the same 5-bit wrap as cnt
  always_comb begin
    n1       = 4'($countones(q_m_q[7:0]));
    disp     = {n1, 1'b0} - 5'd8;
    cnt_zero = (cnt_q == '0);
    cnt_neg  = cnt_q[CNT_W-1];
    cnt_pos  = !cnt_neg && !cnt_zero;
    sym_d    = sym_q;
    cnt_d    = cnt_q;
    if (blank_q) begin
      sym_d = guard_q ? guard_sym : ctrl_symbol(ctl_q);
      cnt_d = '0;
    end else if (cnt_zero || (n1 == 4'd4)) begin
      sym_d = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
      cnt_d = q_m_q[8] ? (cnt_q + disp) : (cnt_q - disp);
    end else if ((cnt_pos && (n1 > 4'd4)) || (cnt_neg && (n1 < 4'd4))) begin
      sym_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
      cnt_d = cnt_q + (q_m_q[8] ? 5'd2 : 5'd0) - disp;
    end else begin
      sym_d = {1'b0, q_m_q[8], q_m_q[7:0]};
      cnt_d = cnt_q + disp - (q_m_q[8] ? 5'd0 : 5'd2);
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      q_m_q   <= '0;
      blank_q <= 1'b1;
      guard_q <= 1'b0;
      ctl_q   <= 2'b00;
      sym_q   <= CTRL_SYM_00;
      cnt_q   <= '0;
    end else begin
      q_m_q   <= q_m_d;
      blank_q <= blank_d;
      guard_q <= guard_d;
      ctl_q   <= ctl_d;
      sym_q   <= sym_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sym = sym_q;

endmodule

// File: rtl/tmds_encoder.sv
// VGA to three-channel TMDS encoder. Define HDMI_GUARD_BAND_EN to add the
// 10-cycle delay line, video preamble and leading guard bands (HDMI mode).
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int C_depth = 8
) (
  input  logic               clk_pixel,
  input  logic               rst_n,
  input  logic [C_depth-1:0] red_p,
  input  logic [C_depth-1:0] green_p,
  input  logic [C_depth-1:0] blue_p,
  input  logic               blank,
  input  logic               hsync,
  input  logic               vsync,
  output logic [9:0]         out_red,
  output logic [9:0]         out_green,
  output logic [9:0]         out_blue
);

  pixel_t     pix_in;
  pixel_t     enc_pix;
  logic [1:0] green_ctl, red_ctl;
  logic       guard;

  // narrow colours sit in the MSBs with zero-filled LSBs
  always_comb begin
    pix_in.blank = blank;
    pix_in.hsync = hsync;
    pix_in.vsync = vsync;
    pix_in.red   = 8'(red_p)   << (8 - C_depth);
    pix_in.green = 8'(green_p) << (8 - C_depth);
    pix_in.blue  = 8'(blue_p)  << (8 - C_depth);
  end

`ifdef HDMI_GUARD_BAND_EN
  pixel_t     dly_d [GUARD_DELAY];
  pixel_t     dly_q [GUARD_DELAY];
  logic       blank_prev_d, blank_prev_q;
  logic [3:0] gb_cnt_d, gb_cnt_q;
  logic       fall;
  logic       preamble;

  // The undelayed blank edge predicts when video leaves the delay line, so the
  // counter marks the 8 preamble and 2 guard slots still inside the blank period.
  always_comb begin
    dly_d[0] = pix_in;
    for (int i = 1; i < GUARD_DELAY; i++) begin
      dly_d[i] = dly_q[i-1];
    end
    blank_prev_d = blank;
    fall         = blank_prev_q && !blank;
    gb_cnt_d     = gb_cnt_q;
    if (fall) begin
      gb_cnt_d = 4'(GUARD_DELAY - 1);
    end else if (gb_cnt_q != 4'd0) begin
      gb_cnt_d = gb_cnt_q - 4'd1;
    end
    enc_pix   = dly_q[GUARD_DELAY-1];
    preamble  = enc_pix.blank && (fall || (gb_cnt_q > 4'(GUARD_LEN)));
    guard     = enc_pix.blank && !fall && (gb_cnt_q != 4'd0) && (gb_cnt_q <= 4'(GUARD_LEN));
    green_ctl = preamble ? PREAMBLE_VIDEO[1:0] : 2'b00;
    red_ctl   = preamble ? PREAMBLE_VIDEO[3:2] : 2'b00;
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < GUARD_DELAY; i++) begin
        dly_q[i] <= PIXEL_IDLE;
      end
      blank_prev_q <= 1'b1;
      gb_cnt_q     <= 4'd0;
    end else begin
      for (int i = 0; i < GUARD_DELAY; i++) begin
        dly_q[i] <= dly_d[i];
      end
      blank_prev_q <= blank_prev_d;
      gb_cnt_q     <= gb_cnt_d;
    end
  end
`else
  always_comb begin
    enc_pix   = pix_in;
    green_ctl = 2'b00;
    red_ctl   = 2'b00;
    guard     = 1'b0;
  end
`endif

  tmds_channel_encoder u_blue (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .data      (enc_pix.blue),
    .ctl       ({enc_pix.vsync, enc_pix.hsync}),
    .blank     (enc_pix.blank),
    .guard     (guard),
    .guard_sym (GUARD_BLUE),
    .sym       (out_blue)
  );

  tmds_channel_encoder u_green (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .data      (enc_pix.green),
    .ctl       (green_ctl),
    .blank     (enc_pix.blank),
    .guard     (guard),
    .guard_sym (GUARD_GREEN),
    .sym       (out_green)
  );

  tmds_channel_encoder u_red (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .data      (enc_pix.red),
    .ctl       (red_ctl),
    .blank     (enc_pix.blank),
    .guard     (guard),
    .guard_sym (GUARD_RED),
    .sym       (out_red)
  );

endmodule
